// File: rtl/divisor_clk_param_pkg.sv
// Shared constants and the divisor clamp for the programmable clock-divider bank.
package divisor_pkg;

  localparam int unsigned LARG_DEF       = 8;
  localparam int unsigned DIV_MIN        = 2;
  localparam int unsigned DIV_PADRAO_DEF = 5;

  // Divisors below DIV_MIN cannot produce a tick/idle pair, so they are raised to it.
  function automatic logic [31:0] limita_divisor(input logic [31:0] valor);
    return (valor < DIV_MIN) ? 32'(DIV_MIN) : valor;
  endfunction

endpackage

// File: rtl/divisor_clk_param_canal.sv
// One divider channel: programmable modulo counter with registered divided clock,
// terminal-count tick and tick-rate toggle.
module canal_divisor
  import divisor_pkg::*;
#(
  parameter int unsigned LARG       = LARG_DEF,
  parameter int unsigned DIV_PADRAO = DIV_PADRAO_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            adv,
  input  logic            carregar_local,
  input  logic [LARG-1:0] divisor_in,
  output logic            clk_div,
  output logic            pulso,
  output logic            alternado
);

  logic [LARG-1:0] cnt;
  logic [LARG-1:0] div;
  logic [LARG-1:0] cnt_prox;
  logic            terminal;

  always_comb begin
    terminal = (cnt == div - LARG'(1));
    cnt_prox = terminal ? '0 : cnt + LARG'(1);
  end

  // Load takes priority over an advance, so a load at terminal count swallows the tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      div       <= LARG'(DIV_PADRAO);
      clk_div   <= 1'b1;
      pulso     <= 1'b0;
      alternado <= 1'b0;
    end else if (carregar_local) begin
      cnt     <= '0;
      div     <= LARG'(limita_divisor(32'(divisor_in)));
      clk_div <= 1'b1;
      pulso   <= 1'b0;
    end else if (adv) begin
      cnt     <= cnt_prox;
      clk_div <= (cnt_prox < (div >> 1));
      pulso   <= terminal;
      if (terminal) alternado <= ~alternado;
    end else begin
      pulso <= 1'b0;
    end
  end

endmodule

// File: rtl/divisor_clk_param.sv
// Bank of NUM_CANAIS runtime-programmable clock dividers, independent or cascaded.
module divisor_clk_param
  import divisor_pkg::*;
#(
  parameter int unsigned NUM_CANAIS = 2,
  parameter int unsigned LARG       = LARG_DEF,
  parameter int unsigned DIV_PADRAO = DIV_PADRAO_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  modo_cascata,
  input  logic                  carregar,
  input  logic [2:0]            canal_sel,
  input  logic [LARG-1:0]       divisor_in,
  output logic [NUM_CANAIS-1:0] clk_div,
  output logic [NUM_CANAIS-1:0] pulso,
  output logic [NUM_CANAIS-1:0] alternado
);

  logic [NUM_CANAIS-1:0] adv;
  logic [NUM_CANAIS-1:0] carrega_sel;

  genvar i;
  generate
    for (i = 0; i < NUM_CANAIS; i++) begin : g_canal
      // Cascade keys on the registered tick of the previous channel, giving an exact product period.
      if (i == 0) begin : g_primeiro
        assign adv[i] = enable;
      end else begin : g_seguinte
        assign adv[i] = enable & (~modo_cascata | pulso[i-1]);
      end

      assign carrega_sel[i] = carregar & (canal_sel == 3'(i));

      canal_divisor #(
        .LARG       (LARG),
        .DIV_PADRAO (DIV_PADRAO)
      ) u_canal (
        .clk            (clk),
        .reset          (reset),
        .adv            (adv[i]),
        .carregar_local (carrega_sel[i]),
        .divisor_in     (divisor_in),
        .clk_div        (clk_div[i]),
        .pulso          (pulso[i]),
        .alternado      (alternado[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_divisor_clk_param.sv
// Testbench for divisor_clk_param: cycle-level reference model feeding a scoreboard,
// plus directed checks of the expected waveforms.
module tb_divisor_clk_param;

  localparam int unsigned NC = 2;
  localparam int unsigned LW = 8;

  logic          clk = 1'b0;
  logic          reset, enable, modo_cascata, carregar;
  logic [2:0]    canal_sel;
  logic [LW-1:0] divisor_in;
  logic [NC-1:0] clk_div, pulso, alternado;

  int n_vec = 0;
  int n_err = 0;

  int m_cnt[NC], m_div[NC];
  bit m_clk[NC], m_pul[NC], m_alt[NC];
  logic [5:0] sb[$];

  always #5 clk = ~clk;

  divisor_clk_param #(
    .NUM_CANAIS (NC),
    .LARG       (LW),
    .DIV_PADRAO (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .modo_cascata (modo_cascata),
    .carregar     (carregar),
    .canal_sel    (canal_sel),
    .divisor_in   (divisor_in),
    .clk_div      (clk_div),
    .pulso        (pulso),
    .alternado    (alternado)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Next-state model of the bank, evaluated from the inputs about to be sampled.
  task automatic model_step();
    bit p_old[NC];
    for (int i = 0; i < NC; i++) p_old[i] = m_pul[i];
    for (int i = 0; i < NC; i++) begin
      bit a;
      a = enable && (!modo_cascata || i == 0 || p_old[(i == 0) ? 0 : i - 1]);
      if (reset) begin
        m_cnt[i] = 0; m_div[i] = 5; m_clk[i] = 1; m_pul[i] = 0; m_alt[i] = 0;
      end else if (carregar && int'(canal_sel) == i) begin
        m_div[i] = (divisor_in < 2) ? 2 : int'(divisor_in);
        m_cnt[i] = 0; m_clk[i] = 1; m_pul[i] = 0;
      end else if (a) begin
        if (m_cnt[i] == m_div[i] - 1) begin
          m_cnt[i] = 0; m_pul[i] = 1; m_alt[i] = !m_alt[i];
        end else begin
          m_cnt[i] = m_cnt[i] + 1; m_pul[i] = 0;
        end
        m_clk[i] = (m_cnt[i] < m_div[i] / 2);
      end else begin
        m_pul[i] = 0;
      end
    end
    sb.push_back({m_clk[1], m_clk[0], m_pul[1], m_pul[0], m_alt[1], m_alt[0]});
  endtask

  task automatic tick();
    logic [5:0] e;
    model_step();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("scoreboard", 32'({clk_div, pulso, alternado}), 32'(e));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [5:0] hold;
    int exp_clk[10];
    int first, second, highs, found;
    exp_clk = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};

    reset = 1'b1; enable = 1'b0; modo_cascata = 1'b0; carregar = 1'b0;
    canal_sel = '0; divisor_in = '0;
    tick();
    do_reset();
    check("reset_state", 32'({clk_div, pulso, alternado}), 32'h30);

    // Free-running, independent channels
    check("free_clk0_0", 32'(clk_div[0]), 32'(exp_clk[0]));
    enable = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k < 10) check("free_clk0", 32'(clk_div[0]), 32'(exp_clk[k]));
      check("free_pulso0", 32'(pulso[0]), 32'((k % 5) == 0));
      check("free_alt0", 32'(alternado[0]), 32'((k / 5) % 2));
    end

    // Cascade: channel 1 period is 25 cycles
    do_reset();
    modo_cascata = 1'b1; enable = 1'b1;
    first = -1; second = -1; highs = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k <= 50 && clk_div[1]) highs++;
      if (pulso[1]) begin
        if (first < 0) first = k; else if (second < 0) second = k;
      end
      if (k == 50) check("casc_alt1_50", 32'(alternado[1]), 32'd1);
      if (k == 51) check("casc_alt1_51", 32'(alternado[1]), 32'd0);
    end
    check("casc_first_tick", 32'(first), 32'd26);
    check("casc_tick_gap", 32'(second - first), 32'd25);
    check("casc_clk1_high", 32'(highs), 32'd20);

    // Load clamp: divisor 1 stored as 2 on channel 0
    do_reset();
    modo_cascata = 1'b0; enable = 1'b0;
    carregar = 1'b1; canal_sel = 3'd0; divisor_in = 8'd1;
    tick();
    carregar = 1'b0; enable = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("clamp_clk0", 32'(clk_div[0]), 32'(k % 2 == 0));
      check("clamp_pulso0", 32'(pulso[0]), 32'(k % 2 == 0));
      check("clamp_pulso1", 32'(pulso[1]), 32'(k == 5 || k == 10));
    end

    // Enable freeze at cnt_0 = 3
    do_reset();
    enable = 1'b1;
    repeat (3) tick();
    enable = 1'b0;
    hold = {clk_div, pulso, alternado};
    for (int k = 0; k < 7; k++) begin
      tick();
      check("freeze_pulso", 32'(pulso), 32'd0);
      check("freeze_clkalt", 32'({clk_div, alternado}), 32'({hold[5:4], hold[1:0]}));
    end
    enable = 1'b1;
    tick();
    check("unfreeze_1", 32'(pulso[0]), 32'd0);
    tick();
    check("unfreeze_2", 32'(pulso[0]), 32'd1);

    // Load collision at terminal count, then 9-cycle period
    do_reset();
    enable = 1'b1;
    repeat (4) tick();
    carregar = 1'b1; canal_sel = 3'd0; divisor_in = 8'd9;
    tick();
    carregar = 1'b0;
    check("collide_no_tick", 32'(pulso[0]), 32'd0);
    found = -1;
    for (int k = 1; k <= 20 && found < 0; k++) begin
      tick();
      if (pulso[0]) found = k;
    end
    check("collide_next_tick", 32'(found), 32'd9);

    // Invalid select is ignored
    enable = 1'b0;
    tick();
    hold = {clk_div, pulso, alternado};
    carregar = 1'b1; canal_sel = 3'd5; divisor_in = 8'd3;
    tick();
    carregar = 1'b0;
    check("bad_sel_hold", 32'({clk_div, pulso, alternado}), 32'(hold));
    enable = 1'b1;
    repeat (5) tick();

    // Reset mid-run overrides a load
    carregar = 1'b1; canal_sel = 3'd1; divisor_in = 8'd7;
    reset = 1'b1;
    tick();
    reset = 1'b0; carregar = 1'b0;
    check("midrst_state", 32'({clk_div, pulso, alternado}), 32'h30);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("midrst_pulso0", 32'(pulso[0]), 32'(k == 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
